ldr_ctrl: RTL and testbench
===========================

LDR_CTRL -- requirements
Module: ldr_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum cycles spent in READ waiting for mem_ack before abort.
REQ-002 Ports SHALL be, in order: clk, rst_n, then functional ports.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ldr_req  in  1  load request; sampled only in IDLE.
REQ-006 ldr_rd  in  4  destination register index 0..15.
REQ-007 ldr_addr  in  32  byte address of word to load.
REQ-008 ldr_busy  out  1  high from accept cycle until return to IDLE.
REQ-009 mem_rd  out  1  memory read strobe, held until ack or timeout.
REQ-010 mem_addr  out  32  captured load address, valid while mem_rd=1.
REQ-011 mem_rdata  in  32  read data, valid when mem_ack=1.
REQ-012 mem_ack  in  1  single-cycle read acknowledge.
REQ-013 enable  out  16  one-hot register-bank write select; all-zero when idle.
REQ-014 ldr_data  out  32  data to register bank; registered.
REQ-015 ldr_done  out  1  one-cycle pulse, coincident with enable.
REQ-016 ldr_err  out  1  one-cycle pulse on misalignment or timeout.

Function
REQ-017 FSM states: IDLE, READ, SETUP, WRITE, ERR; all outputs registered.
REQ-018 IDLE with ldr_req=1 and ldr_addr[1:0]=0: capture ldr_rd, ldr_addr; next READ; mem_rd=1 from next cycle.
REQ-019 IDLE with ldr_req=1 and ldr_addr[1:0]!=0: no memory access; next ERR.
REQ-020 READ: mem_rd=1, mem_addr=captured address; wait counter increments each cycle without ack.
REQ-021 READ with mem_ack=1: ldr_data<=mem_rdata, mem_rd<=0; next SETUP.
REQ-022 READ with counter=TIMEOUT and mem_ack=0: mem_rd<=0; next ERR; ldr_data unchanged.
REQ-023 Ack and timeout in the same cycle: ack wins.
REQ-024 SETUP: one cycle, enable stays zero so ldr_data is stable before any enable edge; next WRITE.
REQ-025 WRITE: enable=one-hot(captured rd) and ldr_done=1 for exactly one cycle; next IDLE.
REQ-026 ERR: ldr_err=1 for exactly one cycle, enable zero; next IDLE.
REQ-027 enable returns to zero for at least one cycle between consecutive writes (bank is edge-sensitive on enable).
REQ-028 Latency: req at cycle 0, ack at cycle k (k>=1) -> enable/ldr_done at cycle k+2.
REQ-029 ldr_req while busy is ignored, not queued; mem_ack outside READ is ignored.
REQ-030 ldr_data holds last loaded value until the next successful ack.
REQ-031 Wait counter cleared on entry to READ; width ceil(log2(TIMEOUT+1)).

Reset
REQ-032 rst_n=0 at a clock edge: state IDLE, enable=0, ldr_data=0, mem_rd=0, mem_addr=0, ldr_busy=0, ldr_done=0, ldr_err=0, counter=0.
REQ-033 Reset mid-transaction aborts it with no enable pulse; a late mem_ack is ignored.

Structure
REQ-034 Shared package holds state enum, REG_COUNT=16, REG_IDX_W=4, DATA_W=32, TIMEOUT default.
REQ-035 One sub-module rd_decode: combinational 4-to-16 one-hot decoder feeding the enable register.

Verification
REQ-036 Reset: assert rst_n=0 two cycles -> all outputs zero, ldr_busy=0.
REQ-037 Load rd=5, addr=0x100, ack at cycle 3 with 0xDEADBEEF -> mem_addr=0x100, ldr_data=0xDEADBEEF at cycle 4, enable=0x0020 and ldr_done at cycle 5 only.
REQ-038 Misaligned addr=0x102 -> ldr_err pulse at cycle 1, mem_rd never asserted, enable stays 0.
REQ-039 No ack, TIMEOUT=15 -> mem_rd drops, ldr_err pulses once, enable 0, ldr_data unchanged.
REQ-040 Back-to-back req held high with rd=0 then rd=15 -> second accepted only after IDLE; enable 0x0001, zero gap, then 0x8000.
REQ-041 rst_n=0 during READ then ack arrives -> no enable, no done, FSM stays IDLE.

Source files
------------

// File: rtl/ldr_ctrl_pkg.sv
// Shared definitions for the load controller: widths, register-bank size and FSM encoding.
package ldr_ctrl_pkg;

    localparam int unsigned REG_COUNT       = 16;
    localparam int unsigned REG_IDX_W       = 4;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StRead  = 3'd1;
    localparam state_t StSetup = 3'd2;
    localparam state_t StWrite = 3'd3;
    localparam state_t StErr   = 3'd4;

endpackage

// File: rtl/ldr_ctrl_rd_decode.sv
// Combinational 4-to-16 one-hot decoder for the register-bank write select.
module rd_decode
    import ldr_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    output logic [REG_COUNT-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/ldr_ctrl.sv
// Load controller: reads one word from memory and writes it into a register bank
// through a one-hot, edge-sensitive enable, with misalignment and timeout aborts.
module ldr_ctrl
    import ldr_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ldr_req,
    input  logic [REG_IDX_W-1:0] ldr_rd,
    input  logic [ADDR_W-1:0]    ldr_addr,
    output logic                 ldr_busy,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic [REG_COUNT-1:0] enable,
    output logic [DATA_W-1:0]    ldr_data,
    output logic                 ldr_done,
    output logic                 ldr_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [REG_IDX_W-1:0] rd_q;
    logic [REG_COUNT-1:0] rd_onehot;
    logic                 aligned;
    logic                 accept;

    assign aligned = (ldr_addr[1:0] == 2'b00);
    assign accept  = (state_q == StIdle) && ldr_req && aligned;

    rd_decode u_rd_decode (
        .idx    (rd_q),
        .onehot (rd_onehot)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (ldr_req) begin
                    state_d = aligned ? StRead : StErr;
                end
            end
            StRead: begin
                // Ack takes priority over an expiring wait counter.
                if (mem_ack) begin
                    state_d = StSetup;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSetup: state_d = StWrite;
            StWrite: state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so each is a clean flop output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rd_q     <= '0;
            mem_addr <= '0;
            ldr_data <= '0;
            ldr_busy <= 1'b0;
            mem_rd   <= 1'b0;
            enable   <= '0;
            ldr_done <= 1'b0;
            ldr_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_q     <= ldr_rd;
                mem_addr <= ldr_addr;
            end
            if ((state_q == StRead) && mem_ack) begin
                ldr_data <= mem_rdata;
            end
            ldr_busy <= (state_d != StIdle);
            mem_rd   <= (state_d == StRead);
            enable   <= (state_d == StWrite) ? rd_onehot : '0;
            ldr_done <= (state_d == StWrite);
            ldr_err  <= (state_d == StErr);
        end
    end

endmodule

// File: tb/tb_ldr_ctrl.sv
// Self-checking bench for ldr_ctrl: reset, vector table, hand sequences and random transactions
// compared cycle by cycle against a transaction-level timing model.
module tb_ldr_ctrl;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ldr_req;
    logic [3:0]  ldr_rd;
    logic [31:0] ldr_addr;
    logic        ldr_busy;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] enable;
    logic [31:0] ldr_data;
    logic        ldr_done;
    logic        ldr_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model memory of what the DUT should be holding between transactions.
    logic [31:0] last_data = '0;
    logic [31:0] last_addr = '0;

    typedef struct {
        logic        busy;
        logic        mrd;
        logic [31:0] maddr;
        logic [15:0] en;
        logic [31:0] data;
        logic        done;
        logic        err;
    } outs_t;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] addr;
        int          k;
        logic [31:0] rdata;
        int          exp_done;
        int          exp_err;
        int          exp_rd_cyc;
        logic [15:0] exp_en;
        logic [31:0] exp_data;
    } vec_t;

    always #5 clk = ~clk;

    ldr_ctrl #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ldr_req   (ldr_req),
        .ldr_rd    (ldr_rd),
        .ldr_addr  (ldr_addr),
        .ldr_busy  (ldr_busy),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .enable    (enable),
        .ldr_data  (ldr_data),
        .ldr_done  (ldr_done),
        .ldr_err   (ldr_err)
    );

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, c, act, exp);
    endtask

    task automatic check_outs(input string tag, input int c, input outs_t e);
        check({tag, " ldr_busy"}, c, 32'(ldr_busy), 32'(e.busy));
        check({tag, " mem_rd"},   c, 32'(mem_rd),   32'(e.mrd));
        check({tag, " mem_addr"}, c, mem_addr,      e.maddr);
        check({tag, " enable"},   c, 32'(enable),   32'(e.en));
        check({tag, " ldr_data"}, c, ldr_data,      e.data);
        check({tag, " ldr_done"}, c, 32'(ldr_done), 32'(e.done));
        check({tag, " ldr_err"},  c, 32'(ldr_err),  32'(e.err));
    endtask

    // Request at cycle 0, ack at cycle k: derive every output of cycle c from the timing rules.
    function automatic outs_t model(input int c, input logic [3:0] rd, input logic [31:0] addr,
                                    input int k, input logic [31:0] rdata);
        outs_t o;
        bit    ok;
        bit    acked;
        int    last;
        int    rd_end;
        ok     = (addr[1:0] == 2'b00);
        acked  = ok && (k >= 1) && (k <= T + 1);
        last   = !ok ? 1 : (acked ? k + 2 : T + 2);
        rd_end = !ok ? 0 : (acked ? k : T + 1);
        o.busy  = (c >= 1) && (c <= last);
        o.mrd   = (c >= 1) && (c <= rd_end);
        o.maddr = (ok && c >= 1) ? addr : last_addr;
        o.en    = (acked && c == k + 2) ? (16'(1) << rd) : 16'h0;
        o.done  = acked && (c == k + 2);
        o.err   = !acked && (c == last);
        o.data  = (acked && c >= k + 1) ? rdata : last_data;
        return o;
    endfunction

    // Starts and ends at posedge+1; noise toggles ldr_req while busy and mem_ack outside READ.
    task automatic run_txn(input logic [3:0] rd, input logic [31:0] addr, input int k,
                           input logic [31:0] rdata, input bit noise, input string tag,
                           output int done_c, output int err_c, output int rd_cycles,
                           output logic [15:0] en_or);
        outs_t e;
        bit    ok;
        bit    acked;
        int    last;
        int    rd_end;
        int    stop;
        ok     = (addr[1:0] == 2'b00);
        acked  = ok && (k >= 1) && (k <= T + 1);
        last   = !ok ? 1 : (acked ? k + 2 : T + 2);
        rd_end = !ok ? 0 : (acked ? k : T + 1);
        stop   = ((k > last) ? k : last) + 1;
        done_c = -1;
        err_c  = -1;
        rd_cycles = 0;
        en_or  = '0;
        for (int c = 0; c <= stop; c++) begin
            if (c == 0) begin
                ldr_req  = 1'b1;
                ldr_rd   = rd;
                ldr_addr = addr;
            end else if (noise && c <= last) begin
                ldr_req  = 1'($urandom);
                ldr_rd   = 4'($urandom);
                ldr_addr = $urandom;
            end else begin
                ldr_req  = 1'b0;
            end
            if (c == k) mem_ack = 1'b1;
            else mem_ack = noise && (c < 1 || c > rd_end) && 1'($urandom);
            mem_rdata = (c == k) ? rdata : $urandom;
            @(negedge clk);
            e = model(c, rd, addr, k, rdata);
            check_outs(tag, c, e);
            if (ldr_done) done_c = c;
            if (ldr_err) err_c = c;
            if (mem_rd) rd_cycles++;
            en_or |= enable;
            @(posedge clk);
            #1;
        end
        ldr_req = 1'b0;
        mem_ack = 1'b0;
        if (acked) last_data = rdata;
        if (ok) last_addr = addr;
    endtask

    initial begin
        vec_t        tbl [7];
        outs_t       zero;
        int          done_c, err_c, rd_cyc;
        logic [15:0] en_or;

        tbl[0] = '{4'd5,  32'h100, 3,  32'hDEADBEEF, 5,  -1, 3,  16'h0020, 32'hDEADBEEF};
        tbl[1] = '{4'd2,  32'h102, 2,  32'h12345678, -1, 1,  0,  16'h0000, 32'hDEADBEEF};
        tbl[2] = '{4'd3,  32'h200, 0,  32'h0,        -1, 17, 16, 16'h0000, 32'hDEADBEEF};
        tbl[3] = '{4'd15, 32'h004, 1,  32'hCAFEF00D, 3,  -1, 1,  16'h8000, 32'hCAFEF00D};
        tbl[4] = '{4'd0,  32'h008, 16, 32'h11111111, 18, -1, 16, 16'h0001, 32'h11111111};
        tbl[5] = '{4'd7,  32'h003, 1,  32'h22222222, -1, 1,  0,  16'h0000, 32'h11111111};
        tbl[6] = '{4'd9,  32'h00C, 17, 32'h33333333, -1, 17, 16, 16'h0000, 32'h11111111};
        zero = '{1'b0, 1'b0, 32'h0, 16'h0, 32'h0, 1'b0, 1'b0};

        // Reset held two cycles with a request pending.
        rst_n = 1'b0; ldr_req = 1'b1; ldr_rd = 4'd3; ldr_addr = 32'h40;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 0, zero);
        @(posedge clk);
        #1;
        rst_n = 1'b1; ldr_req = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].rd, tbl[i].addr, tbl[i].k, tbl[i].rdata, 1'b0,
                    $sformatf("tbl%0d", i), done_c, err_c, rd_cyc, en_or);
            check($sformatf("tbl%0d done cycle", i), i, done_c, tbl[i].exp_done);
            check($sformatf("tbl%0d err cycle", i), i, err_c, tbl[i].exp_err);
            check($sformatf("tbl%0d mem_rd cycles", i), i, rd_cyc, tbl[i].exp_rd_cyc);
            check($sformatf("tbl%0d enable seen", i), i, 32'(en_or), 32'(tbl[i].exp_en));
            check($sformatf("tbl%0d final data", i), i, ldr_data, tbl[i].exp_data);
        end

        // Back-to-back: req held high; rd=0 then rd=15 accepted only once IDLE is reached.
        for (int c = 0; c <= 11; c++) begin
            ldr_req   = (c <= 5);
            ldr_rd    = (c == 0) ? 4'd0 : 4'd15;
            ldr_addr  = (c == 0) ? 32'h10 : 32'h20;
            mem_ack   = (c == 2) || (c == 7);
            mem_rdata = (c == 2) ? 32'hA5A5A5A5 : (c == 7) ? 32'h5A5A0001 : 32'hFFFFFFFF;
            @(negedge clk);
            check("b2b enable", c, 32'(enable),
                  (c == 4) ? 32'h0001 : (c == 9) ? 32'h8000 : 32'h0);
            check("b2b ldr_done", c, 32'(ldr_done), 32'(c == 4 || c == 9));
            check("b2b ldr_busy", c, 32'(ldr_busy), 32'((c >= 1 && c <= 4) || (c >= 6 && c <= 9)));
            check("b2b mem_rd", c, 32'(mem_rd), 32'(c == 1 || c == 2 || c == 6 || c == 7));
            if (c == 1 || c == 6) check("b2b mem_addr", c, mem_addr, (c == 1) ? 32'h10 : 32'h20);
            if (c == 4 || c == 9) check("b2b ldr_data", c, ldr_data,
                                        (c == 4) ? 32'hA5A5A5A5 : 32'h5A5A0001);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        last_data = 32'h5A5A0001;
        last_addr = 32'h20;

        // Reset asserted during READ, then a late ack: nothing must come out.
        for (int c = 0; c <= 7; c++) begin
            ldr_req   = (c == 0);
            ldr_rd    = 4'd4;
            ldr_addr  = 32'h40;
            rst_n     = (c != 2);
            mem_ack   = (c == 3);
            mem_rdata = 32'h77777777;
            @(negedge clk);
            if (c == 1) check("rstmid mem_rd", c, 32'(mem_rd), 32'h1);
            if (c >= 3) check_outs("rstmid", c, zero);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        last_data = '0;
        last_addr = '0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] addr;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            run_txn(4'($urandom), addr, $urandom_range(0, 20), $urandom, 1'b1,
                    $sformatf("rnd%0d", i), done_c, err_c, rd_cyc, en_or);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
